// File: rtl/clkdiv_ctrl_pkg.sv
// Shared types and default constants for the clkdiv run controller.
package clkdiv_ctrl_pkg;

  localparam int CNT_W              = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_DRAIN_CYCLES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

  // Bits needed to count 0 .. max_count-1 (at least one bit).
  function automatic int ctr_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/clkdiv_ctrl_run_watchdog.sv
// Loadable up-counter with clear, enable and a terminal-count flag.
module clkdiv_ctrl_run_watchdog #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Clear has priority over load, load over count.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc = (r_count == i_term);

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run controller for clkdiv: sequences en/busy around one processor run and
// reports the elapsed clkcount, with a watchdog forcing the run to end.
module clkdiv_ctrl #(
  parameter int TIMEOUT_CYCLES = clkdiv_ctrl_pkg::DEF_TIMEOUT_CYCLES,
  parameter int DRAIN_CYCLES   = clkdiv_ctrl_pkg::DEF_DRAIN_CYCLES,
  parameter int CNT_W          = clkdiv_ctrl_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             proc_done,
  input  logic [CNT_W-1:0] clkcount,
  input  logic             ack,
  output logic             div_en,
  output logic             div_busy,
  output logic [CNT_W-1:0] cycles,
  output logic             cycles_valid,
  output logic             timeout,
  output logic             ctrl_busy
);

  import clkdiv_ctrl_pkg::*;

  localparam int WD_W = ctr_width(TIMEOUT_CYCLES);
  localparam int DR_W = ctr_width(DRAIN_CYCLES);
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DR_W-1:0] DR_TERM = DR_W'(DRAIN_CYCLES - 1);

  ctrl_state_t      r_state;
  logic [CNT_W-1:0] r_start_snap;
  logic [CNT_W-1:0] r_end_snap;
  logic [CNT_W-1:0] r_cycles;
  logic             r_div_en;
  logic             r_div_busy;
  logic             r_valid;
  logic             r_timeout;
  logic             r_ctrl_busy;
  logic             w_wd_tc;
  logic             w_dr_tc;

  // Watchdog: cleared in ARM, counts every RUN cycle.
  clkdiv_ctrl_run_watchdog #(.W(WD_W)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == ST_ARM),
    .i_load    (1'b0),
    .i_load_val('0),
    .i_en      (r_state == ST_RUN),
    .i_term    (WD_TERM),
    .o_tc      (w_wd_tc)
  );

  // Drain counter: held at zero outside DRAIN, counts DRAIN cycles.
  clkdiv_ctrl_run_watchdog #(.W(DR_W)) u_drain (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (1'b0),
    .i_load    (r_state != ST_DRAIN),
    .i_load_val('0),
    .i_en      (r_state == ST_DRAIN),
    .i_term    (DR_TERM),
    .o_tc      (w_dr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_start_snap <= '0;
      r_end_snap   <= '0;
      r_cycles     <= '0;
      r_div_en     <= 1'b0;
      r_div_busy   <= 1'b0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_ctrl_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_ARM;
            r_div_en    <= 1'b1;
            r_div_busy  <= 1'b1;
            r_ctrl_busy <= 1'b1;
          end
        end
        ST_ARM: begin
          r_start_snap <= clkcount;
          r_state      <= ST_RUN;
        end
        ST_RUN: begin
          // proc_done outranks a simultaneous watchdog expiry.
          if (proc_done || w_wd_tc) begin
            r_end_snap <= clkcount;
            r_timeout  <= !proc_done;
            r_div_busy <= 1'b0;
            r_state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_dr_tc) begin
            r_cycles <= r_end_snap - r_start_snap;
            r_div_en <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ack) begin
            r_valid     <= 1'b0;
            r_ctrl_busy <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_div_en    <= 1'b0;
          r_div_busy  <= 1'b0;
          r_valid     <= 1'b0;
          r_ctrl_busy <= 1'b0;
        end
      endcase
    end
  end

  assign div_en       = r_div_en;
  assign div_busy     = r_div_busy;
  assign cycles       = r_cycles;
  assign cycles_valid = r_valid;
  assign timeout      = r_timeout;
  assign ctrl_busy    = r_ctrl_busy;

endmodule
